bcd_to_bin: RTL and testbench

- Sequential reverse double-dabble converter for the taxi meter: turns a packed BCD fare/rate value from the keypad entry path back into unsigned binary for the fare arithmetic.
- Inverse of the meter's binary-to-BCD display path.
- Uses one shift-and-correct step per clock under a start/busy/done handshake.
- Flags non-decimal nibbles instead of converting them.

---
 rtl/bcd_to_bin_if.sv | 16 +
 rtl/bcd_to_bin.sv | 95 +++++++++
 tb/tb_bcd_to_bin.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/bcd_to_bin_if.sv
// Handshake bundle for the BCD-to-binary converter: start/operand in,
// busy/done/err/result out.
interface bcd_to_bin_if #(
    parameter int DIGITS = 8,
    parameter int OUT_W  = 32
);
    logic                  start;
    logic [4*DIGITS-1:0]   bcd_in;
    logic                  busy;
    logic                  done;
    logic                  err;
    logic [OUT_W-1:0]      result;

    modport master (output start, bcd_in, input busy, done, err, result);
    modport slave  (input start, bcd_in, output busy, done, err, result);
endinterface

// File: rtl/bcd_to_bin.sv
// Sequential reverse double-dabble: packed BCD keypad value -> unsigned binary.
// One shift-and-correct step per clock; non-decimal nibbles are flagged, not converted.
module bcd_to_bin #(
    parameter int DIGITS = 8,
    parameter int OUT_W  = 32
) (
    input  logic       clk,
    input  logic       rst,
    bcd_to_bin_if.slave bus
);
    localparam int W  = 4 * DIGITS;
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {IDLE, CONV, FIN} state_t;

    state_t              state_q, state_d;
    logic [2*W-1:0]      sr_q, sr_d;       // {bcd half, bin half}
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                err_q, err_d;
    logic [OUT_W-1:0]    result_q, result_d;

    logic [2*W-1:0]      shifted;
    logic                bad;

    // State register and datapath flops; reset aborts any conversion in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            sr_q     <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            sr_q     <= sr_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            result_q <= result_d;
        end
    end

    // Next-state logic: operand capture/validation, shift-and-correct step, completion.
    always_comb begin
        state_d  = state_q;
        sr_d     = sr_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        result_d = result_q;

        // One right shift, then pull every bcd nibble >= 8 back down by 3.
        // Nibbles stay in 5..12, so no borrow crosses a nibble boundary.
        shifted = sr_q >> 1;
        for (int i = 0; i < DIGITS; i++) begin
            if (shifted[W + 4*i + 3])
                shifted[W + 4*i +: 4] = shifted[W + 4*i +: 4] - 4'd3;
        end

        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bus.bcd_in[4*i +: 4] > 4'd9) bad = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    sr_d = {bus.bcd_in, {W{1'b0}}};
                    if (bad) begin
                        err_d    = 1'b1;
                        result_d = '0;
                        state_d  = FIN;
                    end else begin
                        err_d   = 1'b0;
                        cnt_d   = CW'(W);
                        state_d = CONV;
                    end
                end
            end
            CONV: begin
                sr_d  = shifted;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    result_d = shifted[W-1 -: OUT_W];
                    state_d  = FIN;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy   = (state_q == CONV);
    assign bus.done   = (state_q == FIN);
    assign bus.err    = err_q;
    assign bus.result = result_q;
endmodule

// File: tb/tb_bcd_to_bin.sv
// Self-checking bench for bcd_to_bin: directed handshake scenarios plus
// randomized operands checked against a decimal-arithmetic reference model.
module tb_bcd_to_bin;
    localparam int DIGITS = 8;
    localparam int OUT_W  = 32;
    localparam int LAT    = 4 * DIGITS;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    bcd_to_bin_if #(.DIGITS(DIGITS), .OUT_W(OUT_W)) bus ();

    bcd_to_bin #(.DIGITS(DIGITS), .OUT_W(OUT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference: read the nibbles as decimal digits and accumulate.
    task automatic ref_model(input logic [4*DIGITS-1:0] b, output logic [OUT_W-1:0] v, output bit bad);
        longint unsigned acc;
        logic [3:0] nib;
        acc = 0;
        bad = 0;
        for (int d = DIGITS - 1; d >= 0; d--) begin
            nib = b[4*d +: 4];
            if (nib > 9) bad = 1;
            acc = acc * 10 + longint'(nib);
        end
        v = bad ? '0 : OUT_W'(acc);
    endtask

    // Present an operand for one edge; returns 1ns after the accepting edge.
    task automatic do_start(input logic [4*DIGITS-1:0] b);
        bus.start  = 1'b1;
        bus.bcd_in = b;
        @(posedge clk); #1;
        bus.start  = 1'b0;
    endtask

    // Count edges until done, tallying busy cycles; flags overlap and result movement.
    task automatic wait_done(output int cycles, output int busy_cnt, output bit timeout);
        logic [OUT_W-1:0] held;
        held     = bus.result;
        cycles   = 0;
        busy_cnt = 0;
        timeout  = 0;
        while (bus.done !== 1'b1) begin
            if (bus.busy === 1'b1) busy_cnt++;
            if (bus.result !== held) begin
                errors++;
                $display("FAIL result_moved_while_busy got %h want %h", bus.result, held);
            end
            @(posedge clk); #1;
            cycles++;
            if (cycles > 200) begin
                timeout = 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        checks++; if (bus.busy !== 1'b0)   begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0)   begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
        checks++; if (bus.err !== 1'b0)    begin errors++; $display("FAIL reset_err got %b want 0", bus.err); end
        checks++; if (bus.result !== '0)   begin errors++; $display("FAIL reset_result got %h want 0", bus.result); end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
    endtask

    // Convert one operand and check latency, busy width, result, err and done width.
    task automatic run_one(input string name, input logic [4*DIGITS-1:0] b);
        logic [OUT_W-1:0] exp_v;
        bit exp_bad, to;
        int cyc, bc;
        ref_model(b, exp_v, exp_bad);
        do_start(b);
        wait_done(cyc, bc, to);
        checks++;
        if (to) begin errors++; $display("FAIL %s timeout waiting for done", name); end
        checks++;
        if (cyc !== (exp_bad ? 0 : LAT)) begin errors++; $display("FAIL %s latency got %0d want %0d", name, cyc, exp_bad ? 0 : LAT); end
        checks++;
        if (bc !== (exp_bad ? 0 : LAT)) begin errors++; $display("FAIL %s busy_cycles got %0d want %0d", name, bc, exp_bad ? 0 : LAT); end
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL %s busy_with_done got %b want 0", name, bus.busy); end
        checks++;
        if (bus.result !== exp_v) begin errors++; $display("FAIL %s result got %h want %h", name, bus.result, exp_v); end
        checks++;
        if (bus.err !== exp_bad) begin errors++; $display("FAIL %s err got %b want %b", name, bus.err, exp_bad); end
        @(posedge clk); #1;
        checks++;
        if (bus.done !== 1'b0) begin errors++; $display("FAIL %s done_width got %b want 0", name, bus.done); end
    endtask

    task automatic test_directed();
        run_one("zero", 32'h0000_0000);
        run_one("all_nines", 32'h9999_9999);
        checks++;
        if (bus.result !== 32'h05F5_E0FF) begin errors++; $display("FAIL all_nines_const got %h want 05f5e0ff", bus.result); end
        run_one("mid", 32'h0001_2345);
        checks++;
        if (bus.result !== 32'h0000_3039) begin errors++; $display("FAIL mid_const got %h want 00003039", bus.result); end
    endtask

    task automatic test_invalid();
        run_one("invalid", 32'h0000_A000);
        checks++;
        if (bus.err !== 1'b1) begin errors++; $display("FAIL invalid_err_held got %b want 1", bus.err); end
        run_one("after_invalid", 32'h0000_0010);
        checks++;
        if (bus.result !== 32'd10) begin errors++; $display("FAIL after_invalid_const got %0d want 10", bus.result); end
        run_one("invalid_top", 32'hF000_0001);
    endtask

    task automatic test_random();
        logic [4*DIGITS-1:0] b;
        for (int n = 0; n < 24; n++) begin
            for (int d = 0; d < DIGITS; d++)
                b[4*d +: 4] = 4'($urandom_range(0, 9));
            if ($urandom_range(0, 5) == 0)
                b[4*$urandom_range(0, DIGITS-1) +: 4] = 4'($urandom_range(10, 15));
            run_one("random", b);
        end
    endtask

    // Starts during CONV and FIN must be ignored; bcd_in churn must not matter.
    task automatic test_ignore_start();
        int dones;
        do_start(32'h0000_0042);
        dones = 0;
        for (int k = 1; k <= 80; k++) begin
            if (k == 5) begin bus.start = 1'b1; bus.bcd_in = 32'h0000_0099; end
            if (k == 6) begin bus.start = 1'b0; bus.bcd_in = $urandom; end
            if (k == LAT + 1) begin bus.start = 1'b1; bus.bcd_in = 32'h0000_0099; end
            if (k == LAT + 2) bus.start = 1'b0;
            @(posedge clk); #1;
            if (bus.done === 1'b1) dones++;
        end
        checks++;
        if (dones !== 1) begin errors++; $display("FAIL ignore_start done_pulses got %0d want 1", dones); end
        checks++;
        if (bus.result !== 32'd42) begin errors++; $display("FAIL ignore_start result got %0d want 42", bus.result); end
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL ignore_start busy_after got %b want 0", bus.busy); end
    endtask

    task automatic test_async_reset();
        int dones;
        do_start(32'h0000_0123);
        repeat (14) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL async_rst_busy got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL async_rst_done got %b want 0", bus.done); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL async_rst_err got %b want 0", bus.err); end
        checks++; if (bus.result !== '0) begin errors++; $display("FAIL async_rst_result got %h want 0", bus.result); end
        @(negedge clk); rst = 1'b0;
        dones = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) dones++;
        end
        checks++;
        if (dones !== 0) begin errors++; $display("FAIL async_rst_no_done got %0d want 0", dones); end
        run_one("after_reset", 32'h0000_0007);
        checks++;
        if (bus.result !== 32'd7) begin errors++; $display("FAIL after_reset_const got %0d want 7", bus.result); end
    endtask

    // Error bit must also clear on reset, not only on a fresh accept.
    task automatic test_reset_err();
        run_one("pre_rst_invalid", 32'h00B0_0000);
        rst = 1'b1;
        #2;
        checks++;
        if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_clears_err got %b want 0", bus.err); end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        clk        = 1'b0;
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.bcd_in = '0;
        checks     = 0;
        errors     = 0;
        test_reset();
        test_directed();
        test_invalid();
        test_random();
        test_ignore_start();
        test_async_reset();
        test_reset_err();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
